reg_op_seq: RTL and testbench

REG_OP_SEQ -- requirements
Module: reg_op_seq

---
 rtl/reg_op_pkg.sv | 25 ++
 rtl/reg_op_alu.sv | 49 ++++
 rtl/reg_op_seq.sv | 129 ++++++++++++
 tb/tb_reg_op_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_op_pkg.sv
// Shared definitions for the register-operation sequencer: op encodings,
// sequencer state type and register-file address width.
package reg_op_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_SHL1 = 3'b110,
    OP_LDI  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/reg_op_alu.sv
// Combinational datapath of the sequencer: computes the result and carry
// for one op from the captured operands and immediate.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum_s;

  assign sum_s = {1'b0, a} + {1'b0, b};

  // Op decode; carry is only meaningful for ADD, SUB (borrow) and SHL1.
  always_comb begin
    result = {WIDTH{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s[WIDTH-1:0];
        carry  = sum_s[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b) ? 1'b1 : 1'b0;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL1: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_LDI:  result = imm;
      default: begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_op_seq.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WRITE) driving an 8-entry
// register file; one instruction per four cycles, all outputs registered.
module reg_op_seq
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_dst,
  input  logic [REG_ADDR_W-1:0] instr_src_a,
  input  logic [REG_ADDR_W-1:0] instr_src_b,
  input  logic [WIDTH-1:0]      instr_imm,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
  input  logic [WIDTH-1:0]      rf_d_out_a,
  input  logic [WIDTH-1:0]      rf_d_out_b,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]      rf_d_in,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  done
);

  state_e                state_r;
  op_e                   op_r;
  logic [REG_ADDR_W-1:0] dst_r;
  logic [WIDTH-1:0]      imm_r;
  logic [WIDTH-1:0]      opnd_a_r;
  logic [WIDTH-1:0]      opnd_b_r;
  logic                  instr_ready_r;
  logic [REG_ADDR_W-1:0] rd_addr_a_r;
  logic [REG_ADDR_W-1:0] rd_addr_b_r;
  logic                  rf_wr_r;
  logic [REG_ADDR_W-1:0] wr_addr_r;
  logic [WIDTH-1:0]      d_in_r;
  logic                  flag_c_r;
  logic                  flag_z_r;
  logic                  done_r;
  logic [WIDTH-1:0]      alu_result_s;
  logic                  alu_carry_s;

  reg_op_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (opnd_a_r),
    .b      (opnd_b_r),
    .op     (op_r),
    .imm    (imm_r),
    .result (alu_result_s),
    .carry  (alu_carry_s)
  );

  // Sequencer FSM with registered outputs; reset aborts any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      op_r          <= OP_ADD;
      dst_r         <= {REG_ADDR_W{1'b0}};
      imm_r         <= {WIDTH{1'b0}};
      opnd_a_r      <= {WIDTH{1'b0}};
      opnd_b_r      <= {WIDTH{1'b0}};
      instr_ready_r <= 1'b1;
      rd_addr_a_r   <= {REG_ADDR_W{1'b0}};
      rd_addr_b_r   <= {REG_ADDR_W{1'b0}};
      rf_wr_r       <= 1'b0;
      wr_addr_r     <= {REG_ADDR_W{1'b0}};
      d_in_r        <= {WIDTH{1'b0}};
      flag_c_r      <= 1'b0;
      flag_z_r      <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rf_wr_r <= 1'b0;
          done_r  <= 1'b0;
          if (instr_valid) begin
            op_r          <= op_e'(instr_op);
            dst_r         <= instr_dst;
            imm_r         <= instr_imm;
            rd_addr_a_r   <= instr_src_a;
            rd_addr_b_r   <= instr_src_b;
            instr_ready_r <= 1'b0;
            state_r       <= ST_READ;
          end
        end
        ST_READ: begin
          opnd_a_r <= rf_d_out_a;
          opnd_b_r <= rf_d_out_b;
          state_r  <= ST_EXEC;
        end
        ST_EXEC: begin
          d_in_r    <= alu_result_s;
          wr_addr_r <= dst_r;
          flag_c_r  <= alu_carry_s;
          flag_z_r  <= (alu_result_s == {WIDTH{1'b0}}) ? 1'b1 : 1'b0;
          rf_wr_r   <= 1'b1;
          done_r    <= 1'b1;
          state_r   <= ST_WRITE;
        end
        ST_WRITE: begin
          rf_wr_r       <= 1'b0;
          done_r        <= 1'b0;
          instr_ready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
        default: begin
          rf_wr_r       <= 1'b0;
          done_r        <= 1'b0;
          instr_ready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready  = instr_ready_r;
  assign rf_rd_addr_a = rd_addr_a_r;
  assign rf_rd_addr_b = rd_addr_b_r;
  assign rf_wr        = rf_wr_r;
  assign rf_wr_addr   = wr_addr_r;
  assign rf_d_in      = d_in_r;
  assign flag_c       = flag_c_r;
  assign flag_z       = flag_z_r;
  assign done         = done_r;

endmodule

// File: tb/tb_reg_op_seq.sv
// Bench for reg_op_seq: behavioural register-file environment, an
// instruction-level reference model, and directed instruction sequences.
module tb_reg_op_seq;
  import reg_op_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [2:0]   instr_op = 3'd0;
  logic [2:0]   instr_dst = 3'd0;
  logic [2:0]   instr_src_a = 3'd0;
  logic [2:0]   instr_src_b = 3'd0;
  logic [W-1:0] instr_imm = 16'h0000;
  logic [2:0]   rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [W-1:0] rf_d_out_a, rf_d_out_b, rf_d_in;
  logic         rf_wr, flag_c, flag_z, done;

  int checks = 0;
  int passes = 0;
  int wr_count = 0;
  int n_issued = 0;
  logic run_cmp = 1'b0;

  reg_op_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst),
    .instr_src_a(instr_src_a), .instr_src_b(instr_src_b), .instr_imm(instr_imm),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .flag_c(flag_c), .flag_z(flag_z), .done(done)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational reads, write on rising edge.
  logic [W-1:0] rf [8] = '{default: 16'h0000};
  assign rf_d_out_a = rf[rf_rd_addr_a];
  assign rf_d_out_b = rf[rf_rd_addr_b];

  always @(posedge clk) begin
    if (rf_wr) begin
      rf[rf_wr_addr] <= rf_d_in;
      wr_count       <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: {carry, result} of an op, straight from the op table.
  function automatic logic [16:0] model_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] imm);
    logic [16:0] t;
    case (op)
      3'd0:    t = {1'b0, a} + {1'b0, b};
      3'd1:    t = {(a < b), a - b};
      3'd2:    t = {1'b0, a & b};
      3'd3:    t = {1'b0, a | b};
      3'd4:    t = {1'b0, a ^ b};
      3'd5:    t = {1'b0, ~a};
      3'd6:    t = {a, 1'b0};
      default: t = {1'b0, imm};
    endcase
    return t;
  endfunction

  // Instruction-level model: cycles elapsed since accept, own register copy.
  int           m_phase = 0;
  logic [2:0]   m_op = 3'd0, m_dst = 3'd0, m_sa = 3'd0, m_sb = 3'd0;
  logic [15:0]  m_a = 16'h0, m_b = 16'h0, m_imm = 16'h0;
  logic         m_c = 1'b0, m_z = 1'b0;
  logic [15:0]  mregs [8] = '{default: 16'h0000};
  logic [16:0]  m_out;
  assign m_out = model_op(m_op, m_a, m_b, m_imm);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_c     <= 1'b0;
      m_z     <= 1'b0;
    end else begin
      case (m_phase)
        0: if (instr_valid) begin
          m_op     <= instr_op;
          m_dst    <= instr_dst;
          m_sa     <= instr_src_a;
          m_sb     <= instr_src_b;
          m_a      <= mregs[instr_src_a];
          m_b      <= mregs[instr_src_b];
          m_imm    <= instr_imm;
          m_phase  <= 1;
          n_issued <= n_issued + 1;
        end
        1: m_phase <= 2;
        2: begin
          m_c     <= m_out[16];
          m_z     <= (m_out[15:0] == 16'h0000);
          m_phase <= 3;
        end
        default: begin
          mregs[m_dst] <= m_out[15:0];
          m_phase      <= 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset && run_cmp) begin
      chk("ready",  32'(instr_ready), 32'(m_phase == 0));
      chk("rf_wr",  32'(rf_wr),       32'(m_phase == 3));
      chk("done",   32'(done),        32'(m_phase == 3));
      chk("flag_c", 32'(flag_c),      32'(m_c));
      chk("flag_z", 32'(flag_z),      32'(m_z));
      if (m_phase == 1) begin
        chk("rd_addr_a", 32'(rf_rd_addr_a), 32'(m_sa));
        chk("rd_addr_b", 32'(rf_rd_addr_b), 32'(m_sb));
      end
      if (m_phase == 3) begin
        chk("wr_addr", 32'(rf_wr_addr), 32'(m_dst));
        chk("d_in",    32'(rf_d_in),    32'(m_out[15:0]));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                      input logic [2:0] b, input logic [15:0] imm);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = op; instr_dst = d; instr_src_a = a; instr_src_b = b; instr_imm = imm;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout_fail("accept");
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [2:0] d,
                     input logic [2:0] a, input logic [2:0] b, input logic [15:0] imm,
                     input logic [15:0] exp_d, input logic exp_c, input logic exp_z);
    int n;
    send(op, d, a, b, imm);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) timeout_fail(name);
    else begin
      chk({name, "_latency"}, 32'(n), 32'd3);
      chk({name, "_addr"},    32'(rf_wr_addr), 32'(d));
      chk({name, "_data"},    32'(rf_d_in), 32'(exp_d));
      chk({name, "_c"},       32'(flag_c), 32'(exp_c));
      chk({name, "_z"},       32'(flag_z), 32'(exp_z));
    end
    @(negedge clk);
    chk({name, "_commit"}, 32'(rf[d]), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready",   32'(instr_ready), 32'd1);
    chk("rst_rf_wr",   32'(rf_wr), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_flags",   32'({flag_c, flag_z}), 32'd0);
    chk("rst_rd_addr", 32'({rf_rd_addr_a, rf_rd_addr_b}), 32'd0);
    chk("rst_wr",      32'({rf_wr_addr, rf_d_in}), 32'd0);
    run_cmp = 1'b1;

    // Idle with valid low: nothing happens.
    repeat (3) @(negedge clk);
    chk("idle_no_write", 32'(wr_count), 32'd0);

    run("ldi_r1",  OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    run("ldi_r2",  OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0);
    run("ldi_r1b", OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    run("ldi_r2b", OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run("add_wrap", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run("ldi_r1c", OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0002, 16'h0002, 1'b0, 1'b0);
    run("sub_borrow", OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run("sub_self", OP_SUB, 3'd1, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run("ldi_r7",  OP_LDI, 3'd7, 3'd0, 3'd0, 16'h8001, 16'h8001, 1'b0, 1'b0);
    run("shl1",    OP_SHL1, 3'd0, 3'd7, 3'd0, 16'h0000, 16'h0002, 1'b1, 1'b0);
    run("ldi_f0",  OP_LDI, 3'd1, 3'd0, 3'd0, 16'hF0F0, 16'hF0F0, 1'b0, 1'b0);
    run("ldi_0f",  OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0);
    run("and",     OP_AND, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h00F0, 1'b0, 1'b0);
    run("or",      OP_OR,  3'd3, 3'd1, 3'd2, 16'h0000, 16'hFFF0, 1'b0, 1'b0);
    run("xor",     OP_XOR, 3'd3, 3'd1, 3'd2, 16'h0000, 16'hFF00, 1'b0, 1'b0);
    run("not",     OP_NOT, 3'd3, 3'd1, 3'd0, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
    run("ldi_r5",  OP_LDI, 3'd5, 3'd0, 3'd0, 16'h0003, 16'h0003, 1'b0, 1'b0);
    run("add_self", OP_ADD, 3'd5, 3'd5, 3'd5, 16'h0000, 16'h0006, 1'b0, 1'b0);
    run("raw_r5",  OP_ADD, 3'd4, 3'd5, 3'd5, 16'h0000, 16'h000C, 1'b0, 1'b0);

    // Back-to-back: valid held high across three LDIs.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = OP_LDI; instr_dst = 3'd1; instr_imm = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin instr_dst = 3'd2; instr_imm = 16'h2222; end
      else if (k == 1) begin instr_dst = 3'd3; instr_imm = 16'h3333; end
      else instr_valid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("b2b_ready_low", 32'(instr_ready), 32'd0);
      end
      @(negedge clk);
      chk("b2b_ready_high", 32'(instr_ready), 32'd1);
    end
    chk("b2b_r1", 32'(rf[1]), 32'h1111);
    chk("b2b_r2", 32'(rf[2]), 32'h2222);
    chk("b2b_r3", 32'(rf[3]), 32'h3333);
    repeat (2) @(negedge clk);
    chk("write_count", 32'(wr_count), 32'(n_issued));

    // Reset while in WRITE of LDI r6: no write may land.
    send(OP_LDI, 3'd6, 3'd0, 3'd0, 16'hABCD);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) timeout_fail("rst_write_wait");
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_mid_done",  32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(instr_ready), 32'd1);
    chk("rst_mid_r6",    32'(rf[6]), 32'h0000);
    chk("rst_mid_flags", 32'({flag_c, flag_z}), 32'd0);

    run("post_rst", OP_LDI, 3'd6, 3'd0, 3'd0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
